// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse period meter: FSM state encoding and
// parameter-derived sizing helpers.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    PM_IDLE = 2'd0,
    PM_HIGH = 2'd1,
    PM_LOW  = 2'd2
  } pm_state_e;

  localparam logic [1:0] ST_IDLE = PM_IDLE;
  localparam logic [1:0] ST_HIGH = PM_HIGH;
  localparam logic [1:0] ST_LOW  = PM_LOW;

  function automatic int avg_n(input int avg_log2);
    return 1 << avg_log2;
  endfunction

  // Accumulators carry AVG_LOG2 guard bits so a full average cannot overflow.
  function automatic int acc_width(input int cnt_w, input int avg_log2);
    return cnt_w + avg_log2;
  endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall detect on
// the synchronized level.
module sig_sync_edge #(
  parameter int STAGES = 3
) (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              s_q;

  // Chain resets high: a pulse already in progress at reset release is not
  // mistaken for a fresh rising edge.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      s_q    <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      s_q    <= sync_q[STAGES-1];
    end
  end

  assign s    = sync_q[STAGES-1];
  assign rise = s & ~s_q;
  assign fall = ~s & s_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures period and high time of a slow pulse input in clk_100mhz cycles,
// with optional averaging, timeout detection and a registered result stage.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int AVG_LOG2    = 0,
  parameter int TIMEOUT     = 100000000,
  parameter int SYNC_STAGES = 3
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             timeout,
  output logic             overrun,
  output logic [1:0]       state_dbg
);

  localparam int ACC_W = acc_width(CNT_W, AVG_LOG2);
  localparam int N_W   = AVG_LOG2 + 1;
  localparam logic [N_W-1:0]   N_LAST = N_W'(avg_n(AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);

  // Handshake: a result transfers on any cycle where meas_valid and
  // meas_ready are both 1; meas_valid never drops without a transfer.

  logic             s, rise, fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_p, cnt_h, cnt_p_inc, cnt_h_inc;
  logic [ACC_W-1:0] acc_p, acc_h, sum_p, sum_h, avg_p, avg_h;
  logic [N_W-1:0]   n;
  logic             tmo_hit, complete, last, load, accept;

  sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_100mhz(clk_100mhz),
    .rst_n     (rst_n),
    .d         (sig_in),
    .s         (s),
    .rise      (rise),
    .fall      (fall)
  );

  always_comb begin
    cnt_p_inc = (&cnt_p) ? cnt_p : cnt_p + 1'b1;
    cnt_h_inc = (&cnt_h) ? cnt_h : cnt_h + 1'b1;
    tmo_hit   = (state != ST_IDLE) && (cnt_p_inc == TMO);
    complete  = (state == ST_LOW) && rise && !tmo_hit;
    last      = (n == N_LAST);
    load      = complete && last;
    accept    = meas_valid && meas_ready;
    sum_p     = acc_p + ACC_W'(cnt_p);
    sum_h     = acc_h + ACC_W'(cnt_h);
    avg_p     = sum_p >> AVG_LOG2;
    avg_h     = sum_h >> AVG_LOG2;
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt_p <= '0;
      cnt_h <= '0;
      acc_p <= '0;
      acc_h <= '0;
      n     <= '0;
    end else if (tmo_hit) begin
      state <= ST_IDLE;
      cnt_p <= '0;
      cnt_h <= '0;
      acc_p <= '0;
      acc_h <= '0;
      n     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_p <= '0;
          cnt_h <= '0;
          if (rise) begin
            state <= ST_HIGH;
            cnt_p <= CNT_W'(1);
            cnt_h <= CNT_W'(1);
          end
        end
        ST_HIGH: begin
          cnt_p <= cnt_p_inc;
          // The falling-edge cycle is already low, so it is not high time.
          if (fall) state <= ST_LOW;
          else      cnt_h <= cnt_h_inc;
        end
        ST_LOW: begin
          if (complete) begin
            state <= ST_HIGH;
            cnt_p <= CNT_W'(1);
            cnt_h <= CNT_W'(1);
            if (last) begin
              acc_p <= '0;
              acc_h <= '0;
              n     <= '0;
            end else begin
              acc_p <= sum_p;
              acc_h <= sum_h;
              n     <= n + 1'b1;
            end
          end else begin
            cnt_p <= cnt_p_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        period     <= avg_p[CNT_W-1:0];
        high_time  <= avg_h[CNT_W-1:0];
        meas_valid <= 1'b1;
        timeout    <= 1'b0;
        if (meas_valid && !meas_ready) overrun <= 1'b1;
      end else if (accept) begin
        meas_valid <= 1'b0;
      end
      if (tmo_hit) timeout <= 1'b1;
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the period and high time of a slow external pulse signal, counted in cycles of the 100 MHz PLL clock. It is the receive-side counterpart of the pulse generators on the board: it validates their output, and it also feeds measured period and pulse length to downstream frequency-synthesis logic. Results are delivered through a valid/ready register stage, with timeout and overrun status.

## Interface
Parameters:
- CNT_W, 32: width of the period and high-time results.
- AVG_LOG2, 0: number of periods averaged per result is 2^AVG_LOG2 (legal range 0..4).
- TIMEOUT, 100000000: cycles without a rising edge before a timeout is declared.
- SYNC_STAGES, 3: depth of the input synchronizer flops (minimum 2).

Ports:
- clk_100mhz  in  1  the only clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sig_in  in  1  asynchronous pulse input.
- period  out  CNT_W  averaged rising-edge-to-rising-edge interval, in cycles.
- high_time  out  CNT_W  averaged high duration, in cycles.
- meas_valid  out  1  result registers hold an unconsumed result.
- meas_ready  in  1  consumer accepts the result on any cycle where meas_valid and meas_ready are both 1.
- timeout  out  1  no rising edge seen for TIMEOUT cycles.
- overrun  out  1  sticky flag: an unconsumed result was overwritten.

## Operation
- sig_in passes through SYNC_STAGES flops to give s. A rising edge is s=1 with the previous s=0; a falling edge is s=0 with the previous s=1.
- State machine (IDLE, HIGH, LOW):
  - IDLE: counters are cleared. A rising edge moves to HIGH with cnt_p=1 and cnt_h=1. Partial pulses are always discarded.
  - HIGH: cnt_p and cnt_h increment every cycle. A falling edge moves to LOW.
  - LOW: cnt_p increments every cycle. A rising edge completes one period; the state returns to HIGH and both counters restart at 1.
- Period completion: cnt_p is added to acc_p and cnt_h to acc_h, and n increments.
  - When n reaches 2^AVG_LOG2, the block loads period = (acc_p+cnt_p)>>AVG_LOG2 and high_time = (acc_h+cnt_h)>>AVG_LOG2, then clears the accumulators and n.
  - The shift truncates; it does not round.
  - Accumulators are CNT_W+AVG_LOG2 bits wide.
  - cnt_p and cnt_h saturate at all-ones and never wrap.
- Timeout: if cnt_p reaches TIMEOUT in HIGH or LOW, then:
  - timeout is set to 1 and the state goes to IDLE;
  - counters, accumulators and n are cleared, and the partial average is discarded;
  - meas_valid and the result registers are left unchanged.
  - This covers both a stuck-high and a stuck-low input.
  - timeout clears to 0 when the next result is loaded.
- Handshake:
  - A load sets meas_valid=1. An accept with no load in the same cycle clears meas_valid.
  - A load while meas_valid=1 and meas_ready=0 overwrites the result and sets overrun=1.
  - A load and an accept in the same cycle keep meas_valid=1, take the new data, and do not set overrun.
  - overrun clears only on reset.

## Timing
- Reset values: period=0, high_time=0, meas_valid=0, timeout=0, overrun=0, state=IDLE.
- Reset asserted mid-operation aborts everything. After release, the first result needs 2^AVG_LOG2+1 rising edges.
- Latency from a sig_in edge to s: SYNC_STAGES cycles.
- Results appear on the cycle after the completing rising edge is detected, because they are registered.
- Measurement resolution is ±1 cycle, caused by synchronizer phase.
- period and high_time are stable whenever meas_valid=1, except when overwritten as described under Handshake.
- Input pulses narrower than 2 cycles are not guaranteed to be detected.

## Structure
- Package pulse_meter_pkg holds:
  - the state enum (IDLE, HIGH, LOW);
  - AVG_N = 2^AVG_LOG2 expressed as a localparam function;
  - the accumulator width rule.
- One sub-module, sig_sync_edge: the synchronizer chain plus rise/fall detect. Its outputs are s, rise and fall. It is reusable by other input-measuring blocks.

## Test plan
- Square wave, period 100 cycles, high 10, AVG_LOG2=0, meas_ready=1 -> after the second rise: period=100, high_time=10, one-cycle meas_valid pulses, no overrun.
- AVG_LOG2=2, periods 100, 100, 104, 101 with high 20 -> a single result with period=101 (truncated from 101.25) and high_time=20.
- TIMEOUT=1000, input stuck low after a result -> timeout=1 exactly 1000 cycles after the last rise; meas_valid and data are unchanged; the next two rises clear timeout and give a new result.
- meas_ready=0 across two completions, periods 100 then 200 -> overrun=1, period=200, meas_valid=1. Raising ready for one cycle clears meas_valid; overrun stays 1.
- rst_n pulsed low in the middle of a HIGH phase -> all outputs 0 immediately. The partial pulse is discarded, and the first result equals the true period measured between two fresh rises.
- Completion coinciding with meas_ready=1 while meas_valid=1 -> meas_valid stays 1, the data updates, and overrun stays 0.
